// File: rtl/fpga_result_fifo.sv
// rtl/fpga_result_fifo.sv - result FIFO packed into a 32-bit status/data word for HPS polling
// Optional READ_EDGE_EN: pop only on the rising edge of read instead of every read-high cycle.
module fpga_result_fifo #(
   parameter int DATA_W  = 24,
   parameter int DEPTH   = 16,
   parameter int LEVEL_W = 6
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              read,
   input  logic              clr_ovf,
   output logic [31:0]       Q_export
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0]  mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LEVEL_W-1:0] level_q, level_d;
   logic               ovf_q, ovf_d;
   logic               read_ev;
   logic               push;
   logic               pop;
   logic               not_empty;
   logic [23:0]        head_data;

`ifdef READ_EDGE_EN
   logic read_dly_q, read_dly_d;

   assign read_dly_d = read;
   assign read_ev    = read && !read_dly_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         read_dly_q <= 1'b0;
      end else begin
         read_dly_q <= read_dly_d;
      end
   end
`else
   assign read_ev = read;
`endif

   assign not_empty = (level_q != '0);
   assign in_ready  = (level_q != LEVEL_W'(DEPTH));
   assign push      = in_valid && in_ready;
   // A read on an empty FIFO is ignored, even if a word is pushed that same cycle.
   assign pop       = read_ev && not_empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      ovf_d    = ovf_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop) begin
         level_d = level_q + 1'b1;
      end else if (pop && !push) begin
         level_d = level_q - 1'b1;
      end
      // A new drop beats a same-cycle clear.
      if (in_valid && !in_ready) begin
         ovf_d = 1'b1;
      end else if (clr_ovf) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q] <= in_data;
   end

   // Stale memory is masked so an empty FIFO always reads back as zero data.
   assign head_data = not_empty ? 24'(mem_q[rd_ptr_q]) : 24'd0;
   assign Q_export  = {not_empty, ovf_q, level_q, head_data};

endmodule
